frame_flip_controller: RTL and testbench
========================================

// Module: frame_flip_controller
// PURPOSE
//  Double-buffer sequencer for the display frame RAM: one simple-dual-port RAM holds two banks (front/back).
//  Routes SPI-loader writes into the back bank and scanner reads to the front bank.
//  Swaps banks at a scanner frame boundary once a frame is loaded, then copies front->back so partial-row updates stay coherent.
//  Arbitrates the single RAM read port between the scanner (priority) and the copy engine.
// PARAMETERS
//  ROWS     8   addressable rows per frame; RB = $clog2(ROWS)
//  COLUMNS  32  columns per row; CB = $clog2(COLUMNS)
//  WIDTH    24  bits per RAM word (segments*bitwidth*3); AW = 1+RB+CB, bank bit is MSB
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous, active-high reset
//  wr_en       in   1      loader write strobe
//  wr_row      in   RB     loader row
//  wr_col      in   CB     loader column
//  wr_data     in   WIDTH  loader data
//  loaded      in   1      loader 1-cycle pulse: back bank holds a complete frame
//  ready       out  1      back bank writable; loader acts on 0->1 edge
//  scan_ren    in   1      scanner read request (always granted)
//  scan_row    in   RB     scanner row
//  scan_col    in   CB     scanner column
//  frame_end   in   1      scanner 1-cycle pulse: last pixel of frame issued
//  ram_waddr   out  AW     RAM write address
//  ram_wdata   out  WIDTH  RAM write data
//  ram_wen     out  1      RAM write enable
//  ram_raddr   out  AW     RAM read address (combinational mux)
//  ram_ren     out  1      RAM read enable (combinational)
//  ram_rdata   in   WIDTH  RAM read data, valid 1 cycle after ram_ren
//  front_bank  out  1      bank currently displayed
//  flipped     out  1      1-cycle pulse on bank swap
// BEHAVIOUR
//  Reset: state INIT, front_bank=0, ready=0, ram_wen=0, flipped=0, copy counter=0, copy pipeline cleared. Reset mid-copy aborts the copy.
//  INIT -> WRITE after 1 cycle; ready=1 (registered) while in WRITE, else 0.
//  WRITE: wr_en registered to RAM, 1-cycle latency: ram_wen=1, ram_waddr={~front_bank,wr_row,wr_col}, ram_wdata=wr_data.
//    loaded=1 -> PENDING. frame_end in same cycle as loaded is ignored.
//  PENDING: wr_en dropped (no RAM write). frame_end=1 -> FLIP.
//  FLIP (1 cycle): front_bank toggles, flipped=1 on the following cycle, -> COPY.
//  COPY: counter walks addr 0..ROWS*COLUMNS-1, row-major, col fastest.
//    Issue: if scan_ren=0, ram_ren=1, ram_raddr={front_bank,addr}, counter++. If scan_ren=1, stall: no issue, counter held.
//    Writeback (1 cycle after issue): ram_wen=1, ram_waddr={~front_bank,addr_d}, ram_wdata=ram_rdata.
//    After the writeback of the last address -> WRITE (ready rises next cycle).
//    Uncontended copy takes ROWS*COLUMNS+1 cycles. loaded, frame_end and wr_en are ignored.
//  Read mux: when not issuing a copy read, ram_raddr={front_bank,scan_row,scan_col}, ram_ren=scan_ren. Scanner latency is never altered.
//  COLUMNS or ROWS not a power of 2: the counter wraps at ROWS*COLUMNS, and unused addresses are never touched.
//  loaded outside WRITE is ignored; the loader gates writes itself while ready is low.
// TESTING
//  Reset: hold rst 3 cycles, release -> ready=0 one cycle then 1; front_bank=0; ram_wen=0 throughout.
//  Write: in WRITE, wr_en=1 row=3 col=5 data=0xABCDEF -> next cycle ram_wen=1, ram_waddr={1,3'd3,5'd5}=0x165, ram_wdata=0xABCDEF.
//  Flip: loaded pulse, frame_end 10 cycles later -> ready=0 from cycle after loaded; flipped pulse; front_bank=1; 256 copy writes to bank 0 addrs 0x000-0x0FF; ready=1 after 257+ cycles.
//  Contention: scan_ren held 1 for 50 cycles during COPY -> scanner reads unaffected, no copy issue in those cycles, COPY ends 50 cycles later; back bank equals front word-for-word.
//  Coincident: loaded and frame_end in same cycle -> no flip; flip occurs on the next frame_end.
//  Reset mid-COPY at addr 100 -> front_bank=0, ram_wen=0, ready 0 then 1; a following loaded/frame_end flips normally.

Source files
------------

// File: rtl/frame_flip_controller.sv
// Double-buffer sequencer for the display frame RAM: loader writes go to the back bank and scanner reads to the front bank.
// A flip at a frame boundary is followed by a front->back copy that shares the read port with the scanner.
module frame_flip_controller #(
    parameter int ROWS    = 8,
    parameter int COLUMNS = 32,
    parameter int WIDTH   = 24,
    localparam int RB = $clog2(ROWS),
    localparam int CB = $clog2(COLUMNS),
    localparam int AW = 1 + RB + CB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [RB-1:0]    wr_row,
    input  logic [CB-1:0]    wr_col,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             loaded,
    output logic             ready,
    input  logic             scan_ren,
    input  logic [RB-1:0]    scan_row,
    input  logic [CB-1:0]    scan_col,
    input  logic             frame_end,
    output logic [AW-1:0]    ram_waddr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_wen,
    output logic [AW-1:0]    ram_raddr,
    output logic             ram_ren,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic             front_bank,
    output logic             flipped
);
    typedef enum logic [2:0] {INIT, WRITE, PENDING, FLIP, COPY} state_t;

    localparam logic [RB-1:0] LAST_ROW = RB'(ROWS - 1);
    localparam logic [CB-1:0] LAST_COL = CB'(COLUMNS - 1);

    state_t            state_reg, state_next;
    logic              front_bank_reg, ready_reg, flipped_reg;
    logic              wr_valid_reg;
    logic [AW-1:0]     wr_addr_reg;
    logic [WIDTH-1:0]  wr_data_reg;
    logic [RB-1:0]     copy_row_reg;
    logic [CB-1:0]     copy_col_reg;
    logic              issue_done_reg;
    logic              wb_valid_reg, wb_last_reg;
    logic [RB+CB-1:0]  wb_addr_reg;
    logic              copy_issue, copy_last;

    always_comb begin
        state_next = state_reg;
        copy_last  = (copy_row_reg == LAST_ROW) && (copy_col_reg == LAST_COL);
        // The scanner always wins the read port; the copy only issues in idle slots.
        copy_issue = (state_reg == COPY) && !scan_ren && !issue_done_reg;
        ram_ren    = copy_issue | scan_ren;
        ram_raddr  = copy_issue ? {front_bank_reg, copy_row_reg, copy_col_reg}
                                : {front_bank_reg, scan_row, scan_col};
        ram_wen    = wr_valid_reg | wb_valid_reg;
        ram_waddr  = wb_valid_reg ? {~front_bank_reg, wb_addr_reg} : wr_addr_reg;
        ram_wdata  = wb_valid_reg ? ram_rdata : wr_data_reg;
        case (state_reg)
            INIT:    state_next = WRITE;
            WRITE:   if (loaded) state_next = PENDING;
            PENDING: if (frame_end) state_next = FLIP;
            FLIP:    state_next = COPY;
            COPY:    if (wb_valid_reg && wb_last_reg) state_next = WRITE;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= INIT;
            front_bank_reg <= 1'b0;
            ready_reg      <= 1'b0;
            flipped_reg    <= 1'b0;
            wr_valid_reg   <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            copy_row_reg   <= '0;
            copy_col_reg   <= '0;
            issue_done_reg <= 1'b0;
            wb_valid_reg   <= 1'b0;
            wb_last_reg    <= 1'b0;
            wb_addr_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            ready_reg    <= (state_next == WRITE);
            flipped_reg  <= (state_reg == FLIP);
            wr_valid_reg <= (state_reg == WRITE) && wr_en;
            if ((state_reg == WRITE) && wr_en) begin
                wr_addr_reg <= {~front_bank_reg, wr_row, wr_col};
                wr_data_reg <= wr_data;
            end
            if (state_reg == FLIP) begin
                front_bank_reg <= ~front_bank_reg;
                copy_row_reg   <= '0;
                copy_col_reg   <= '0;
                issue_done_reg <= 1'b0;
            end else if (copy_issue) begin
                // Explicit wrap keeps non-power-of-two geometries off unused addresses.
                if (copy_col_reg == LAST_COL) begin
                    copy_col_reg <= '0;
                    copy_row_reg <= (copy_row_reg == LAST_ROW) ? '0 : copy_row_reg + 1'b1;
                end else begin
                    copy_col_reg <= copy_col_reg + 1'b1;
                end
                if (copy_last) issue_done_reg <= 1'b1;
            end
            wb_valid_reg <= copy_issue;
            wb_last_reg  <= copy_issue && copy_last;
            if (copy_issue) wb_addr_reg <= {copy_row_reg, copy_col_reg};
        end
    end

    assign ready      = ready_reg;
    assign front_bank = front_bank_reg;
    assign flipped    = flipped_reg;
endmodule

// File: tb/tb_frame_flip_controller.sv
// Scoreboard bench for frame_flip_controller with a behavioural dual-bank RAM attached.
module tb_frame_flip_controller;
    localparam int ROWS = 8, COLUMNS = 32, WIDTH = 24;
    localparam int RB = 3, CB = 5, AW = 9, NWORDS = ROWS * COLUMNS;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic [RB-1:0] wr_row = '0;
    logic [CB-1:0] wr_col = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic loaded = 1'b0;
    logic scan_ren = 1'b0;
    logic [RB-1:0] scan_row = '0;
    logic [CB-1:0] scan_col = '0;
    logic frame_end = 1'b0;
    logic ready, ram_wen, ram_ren, front_bank, flipped;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;

    logic [WIDTH-1:0] mem [0:2*NWORDS-1];
    logic [WIDTH-1:0] shadow [0:2*NWORDS-1];
    logic preload = 1'b1;
    logic sb_enable = 1'b0;
    wr_t exp_q[$];
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    frame_flip_controller #(.ROWS(ROWS), .COLUMNS(COLUMNS), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .loaded(loaded), .ready(ready), .scan_ren(scan_ren),
        .scan_row(scan_row), .scan_col(scan_col), .frame_end(frame_end),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
        .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata),
        .front_bank(front_bank), .flipped(flipped)
    );

    function automatic logic [WIDTH-1:0] pat(input int i);
        return {8'(i), 8'(i >> 1) ^ 8'hA5, 8'(i * 7)};
    endfunction

    // Behavioural RAM: registered read, one cycle latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2 * NWORDS; i++) mem[i] <= pat(i);
        end else if (ram_wen === 1'b1) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_ren === 1'b1) ram_rdata <= mem[ram_raddr];
    end

    // Every RAM write must match the oldest expected write.
    always @(negedge clk) begin : write_monitor
        wr_t e;
        if (sb_enable && ram_wen === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_write got addr=%h data=%h expected no write", ram_waddr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({ram_waddr, ram_wdata} !== e)
                    $display("FAIL sb_write got addr=%h data=%h expected addr=%h data=%h",
                             ram_waddr, ram_wdata, e.addr, e.data);
                else passed++;
            end
        end
    end

    task automatic push_exp(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        shadow[a] = d;
    endtask

    task automatic push_copy(input logic fb_new);
        for (int a = 0; a < NWORDS; a++)
            push_exp({~fb_new, (RB+CB)'(a)}, shadow[{fb_new, (RB+CB)'(a)}]);
    endtask

    task automatic drive_write(input logic [RB-1:0] r, input logic [CB-1:0] c,
                               input logic [WIDTH-1:0] d, input logic bank);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
        push_exp({bank, r, c}, d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ram_wen !== 1'b0 || ready !== 1'b0 || flipped !== 1'b0)
                $display("FAIL reset_hold got wen=%b ready=%b flipped=%b expected 0/0/0", ram_wen, ready, flipped);
            else passed++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || front_bank !== 1'b0)
            $display("FAIL reset_init got ready=%b front=%b expected 0/0", ready, front_bank);
        else passed++;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) $display("FAIL reset_ready got %b expected 1", ready);
        else passed++;
    endtask

    task automatic test_write();
        drive_write(3'd3, 5'd5, 24'hABCDEF, 1'b1);
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_wen !== 1'b1 || ram_waddr !== 9'h165 || ram_wdata !== 24'hABCDEF)
            $display("FAIL write_single got wen=%b addr=%h data=%h expected 1/165/abcdef", ram_wen, ram_waddr, ram_wdata);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            drive_write(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 24'($urandom), 1'b1);
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_drain got %0d pending expected 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_flip();
        int n;
        @(posedge clk); #1; loaded = 1'b1;
        // This write lands in PENDING and must be dropped.
        @(posedge clk); #1; loaded = 1'b0; wr_en = 1'b1; wr_row = 3'd1; wr_col = 5'd2; wr_data = 24'h123456;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) $display("FAIL flip_ready_low got %b expected 0", ready);
        else passed++;
        @(posedge clk); #1; wr_en = 1'b0;
        repeat (8) @(posedge clk);
        #1; frame_end = 1'b1;
        push_copy(1'b1);
        @(posedge clk); #1; frame_end = 1'b0;
        n = 0;
        while (flipped !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n != 2 || front_bank !== 1'b1)
            $display("FAIL flip_pulse got delay=%0d front=%b expected 2/1", n, front_bank);
        else passed++;
        @(negedge clk);
        checks++;
        if (flipped !== 1'b0) $display("FAIL flip_one_cycle got %b expected 0", flipped);
        else passed++;
        n = 1;
        while (ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (n != 257) $display("FAIL copy_length got %0d expected 257", n);
        else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL copy_drain got %0d pending expected 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_contention();
        int n, k, bad;
        logic prev_scan;
        logic [AW-1:0] prev_addr;
        drive_write(3'd2, 5'd9, 24'h5EED01, 1'b0);
        @(posedge clk); #1; wr_en = 1'b0; loaded = 1'b1;
        @(posedge clk); #1; loaded = 1'b0;
        repeat (3) @(posedge clk);
        #1; frame_end = 1'b1;
        push_copy(1'b0);
        @(posedge clk); #1; frame_end = 1'b0;
        n = 0;
        while (flipped !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n != 2 || front_bank !== 1'b0)
            $display("FAIL cont_flip got delay=%0d front=%b expected 2/0", n, front_bank);
        else passed++;
        k = 0;
        prev_scan = 1'b0;
        prev_addr = '0;
        while (ready !== 1'b1 && k < 1000) begin
            @(posedge clk); #1;
            if (prev_scan) begin
                checks++;
                if (ram_rdata !== shadow[prev_addr])
                    $display("FAIL scan_rdata got %h expected %h at %h", ram_rdata, shadow[prev_addr], prev_addr);
                else passed++;
            end
            k++;
            scan_ren = (k >= 20 && k < 70);
            scan_row = 3'($urandom_range(0, 7));
            scan_col = 5'($urandom_range(0, 31));
            @(negedge clk);
            if (scan_ren) begin
                checks++;
                if (ram_ren !== 1'b1 || ram_raddr !== {1'b0, scan_row, scan_col})
                    $display("FAIL scan_raddr got ren=%b addr=%h expected 1/%h", ram_ren, ram_raddr, {1'b0, scan_row, scan_col});
                else passed++;
            end
            prev_scan = scan_ren;
            prev_addr = {1'b0, scan_row, scan_col};
        end
        scan_ren = 1'b0;
        checks++;
        if (k != 307) $display("FAIL cont_length got %0d expected 307", k);
        else passed++;
        bad = 0;
        for (int i = 0; i < NWORDS; i++)
            if (mem[i] !== mem[i + NWORDS] || mem[i] !== shadow[i]) bad++;
        checks++;
        if (bad != 0) $display("FAIL cont_banks_equal got %0d differing words expected 0", bad);
        else passed++;
    endtask

    task automatic test_coincident();
        int n;
        drive_write(3'd7, 5'd31, 24'hC0FFEE, 1'b1);
        @(posedge clk); #1; wr_en = 1'b0; loaded = 1'b1; frame_end = 1'b1;
        @(posedge clk); #1; loaded = 1'b0; frame_end = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (flipped !== 1'b0 || front_bank !== 1'b0 || ready !== 1'b0)
                $display("FAIL coinc_no_flip got flipped=%b front=%b ready=%b expected 0/0/0", flipped, front_bank, ready);
            else passed++;
        end
        @(posedge clk); #1; frame_end = 1'b1;
        push_copy(1'b1);
        @(posedge clk); #1; frame_end = 1'b0;
        n = 0;
        while (flipped !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n != 2 || front_bank !== 1'b1)
            $display("FAIL coinc_flip got delay=%0d front=%b expected 2/1", n, front_bank);
        else passed++;
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (n != 257 || exp_q.size() != 0)
            $display("FAIL coinc_copy got len=%0d pending=%0d expected 257/0", n, exp_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid_copy();
        int n, bad;
        @(posedge clk); #1; loaded = 1'b1;
        @(posedge clk); #1; loaded = 1'b0; frame_end = 1'b1;
        push_copy(1'b0);
        @(posedge clk); #1; frame_end = 1'b0;
        n = 0;
        while (flipped !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n != 2 || front_bank !== 1'b0)
            $display("FAIL mid_flip got delay=%0d front=%b expected 2/0", n, front_bank);
        else passed++;
        repeat (100) @(negedge clk);
        @(posedge clk); #1;
        sb_enable = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (ram_wen !== 1'b0 || front_bank !== 1'b0 || ready !== 1'b0 || flipped !== 1'b0)
            $display("FAIL mid_reset got wen=%b front=%b ready=%b flipped=%b expected 0/0/0/0",
                     ram_wen, front_bank, ready, flipped);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_enable = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) $display("FAIL mid_ready_low got %b expected 0", ready);
        else passed++;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) $display("FAIL mid_ready_high got %b expected 1", ready);
        else passed++;
        @(posedge clk); #1; loaded = 1'b1;
        @(posedge clk); #1; loaded = 1'b0; frame_end = 1'b1;
        push_copy(1'b1);
        @(posedge clk); #1; frame_end = 1'b0;
        n = 0;
        while (flipped !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n != 2 || front_bank !== 1'b1)
            $display("FAIL post_flip got delay=%0d front=%b expected 2/1", n, front_bank);
        else passed++;
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (n != 257 || exp_q.size() != 0)
            $display("FAIL post_copy got len=%0d pending=%0d expected 257/0", n, exp_q.size());
        else passed++;
        bad = 0;
        for (int i = 0; i < 2 * NWORDS; i++)
            if (mem[i] !== shadow[i]) bad++;
        checks++;
        if (bad != 0) $display("FAIL final_ram got %0d differing words expected 0", bad);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 2 * NWORDS; i++) shadow[i] = pat(i);
        @(posedge clk); #1;
        preload = 1'b0;
        sb_enable = 1'b1;
        test_reset();
        test_write();
        test_back_to_back();
        test_flip();
        test_contention();
        test_coincident();
        test_reset_mid_copy();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
